// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard controller for the 5-stage RV32I core.
// Produces the per-register stall vector and the IF/ID flush strobe from
// load-use, data-memory wait and taken-branch events, plus a sticky
// watchdog flag for memory accesses that never complete.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl #(
  parameter int unsigned WAIT_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_reg1_read,
  input  logic [4:0]  id_reg1_addr,
  input  logic        id_reg2_read,
  input  logic [4:0]  id_reg2_addr,
  input  logic        id_branch_flag,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_waddr,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic [5:0]  stall,
  output logic        flush_if_id,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MEM_WAIT  = 2'd1,
    LU_BUBBLE = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(WAIT_TIMEOUT);

  state_t      r_state;
  logic [7:0]  r_wait_cnt;
  logic        r_mem_timeout;

  logic        w_mem_wait;
  logic        w_load_use;
  logic        w_rs1_hit;
  logic        w_rs2_hit;
  logic [5:0]  w_stall;
  logic        w_flush;
  logic [7:0]  w_cnt_next;

  // Hazard detection from the live ID/EX/MEM inputs
  always_comb begin
    w_mem_wait = mem_req & ~mem_ready;
    w_rs1_hit  = id_reg1_read & (id_reg1_addr == ex_waddr);
    w_rs2_hit  = id_reg2_read & (id_reg2_addr == ex_waddr);
    w_load_use = ex_is_load & (ex_waddr != 5'd0) & (w_rs1_hit | w_rs2_hit);
  end

  // Stall vector and flush strobe, prioritised: memory wait, load-use, branch
  always_comb begin
    w_stall = '0;
    w_flush = 1'b0;
    if (!rst) begin
      if (w_mem_wait) begin
        w_stall = 6'b011111;
      end else if (w_load_use) begin
        w_stall = 6'b000111;
      end
      w_flush = id_branch_flag & ~w_stall[1];
    end
  end

  // Next wait count: restart at 1 on entry, otherwise saturating increment
  always_comb begin
    w_cnt_next = 8'd1;
    if (r_state == MEM_WAIT) begin
      w_cnt_next = (r_wait_cnt == 8'hFF) ? 8'hFF : r_wait_cnt + 8'd1;
    end
  end

  // Sequencer state, wait counter and sticky watchdog flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mem_wait) begin
            r_state <= MEM_WAIT;
          end else if (w_load_use) begin
            r_state <= LU_BUBBLE;
          end
        end
        MEM_WAIT: begin
          if (!w_mem_wait) begin
            r_state <= RUN;
          end
        end
        LU_BUBBLE: begin
          r_state <= w_mem_wait ? MEM_WAIT : RUN;
        end
        default: begin
          r_state <= RUN;
        end
      endcase

      // The first wait cycle is seen while still in RUN/LU_BUBBLE, so the
      // count already holds 1 when MEM_WAIT is entered.
      if (w_mem_wait) begin
        r_wait_cnt <= w_cnt_next;
        if (w_cnt_next >= TIMEOUT_CNT) begin
          r_mem_timeout <= 1'b1;
        end
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  assign stall       = w_stall;
  assign flush_if_id = w_flush;
  assign mem_timeout = r_mem_timeout;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  // Free-running wrap-around performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_stall != 6'd0) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_flush) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a
// cycle-level reference model derived from the hazard rules.
module tb_pipe_ctrl;

  localparam int unsigned WT = 4;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        id_reg1_read;
  logic [4:0]  id_reg1_addr;
  logic        id_reg2_read;
  logic [4:0]  id_reg2_addr;
  logic        id_branch_flag;
  logic        ex_is_load;
  logic [4:0]  ex_waddr;
  logic        mem_req;
  logic        mem_ready;
  logic [5:0]  stall;
  logic        flush_if_id;
  logic        mem_timeout;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // reference model state
  int unsigned m_run_len = 0;
  bit          m_tmo     = 1'b0;
  logic [31:0] m_scyc    = '0;
  logic [31:0] m_fcnt    = '0;

  pipe_ctrl #(.WAIT_TIMEOUT(WT)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_reg1_read   (id_reg1_read),
    .id_reg1_addr   (id_reg1_addr),
    .id_reg2_read   (id_reg2_read),
    .id_reg2_addr   (id_reg2_addr),
    .id_branch_flag (id_branch_flag),
    .ex_is_load     (ex_is_load),
    .ex_waddr       (ex_waddr),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .stall          (stall),
    .flush_if_id    (flush_if_id),
    .mem_timeout    (mem_timeout),
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    rst            = 1'b0;
    id_reg1_read   = 1'b0;
    id_reg1_addr   = '0;
    id_reg2_read   = 1'b0;
    id_reg2_addr   = '0;
    id_branch_flag = 1'b0;
    ex_is_load     = 1'b0;
    ex_waddr       = '0;
    mem_req        = 1'b0;
    mem_ready      = 1'b0;
  endtask

  // Inputs are already applied (posedge+1). Check mid-cycle, then advance
  // the model across the next rising edge.
  task automatic step();
    bit          lu;
    bit          mw;
    logic [5:0]  es;
    bit          ef;
    #4;
    lu = ex_is_load && (ex_waddr != 0) &&
         ((id_reg1_read && id_reg1_addr == ex_waddr) ||
          (id_reg2_read && id_reg2_addr == ex_waddr));
    mw = mem_req && !mem_ready;
    if (rst)     es = 6'd0;
    else if (mw) es = 6'b011111;
    else if (lu) es = 6'b000111;
    else         es = 6'd0;
    ef = !rst && id_branch_flag && !es[1];
    check("stall", 32'(stall), 32'(es));
    check("flush", 32'(flush_if_id), 32'(ef));
    check("timeout", 32'(mem_timeout), 32'(m_tmo));
    check("stall_cycles", stall_cycles, PERF ? m_scyc : 32'd0);
    check("flush_count", flush_count, PERF ? m_fcnt : 32'd0);
    @(posedge clk);
    if (rst) begin
      m_run_len = 0;
      m_tmo     = 1'b0;
      m_scyc    = '0;
      m_fcnt    = '0;
    end else begin
      m_run_len = mw ? m_run_len + 1 : 0;
      if (m_run_len >= WT) m_tmo = 1'b1;
      if (es != 0) m_scyc = m_scyc + 32'd1;
      if (ef)      m_fcnt = m_fcnt + 32'd1;
    end
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    // reset held with noisy inputs
    mem_req = 1'b1; id_branch_flag = 1'b1;
    step();
    step();
    idle();

    // load-use on rs1, then release
    ex_is_load = 1'b1; ex_waddr = 5'd5; id_reg1_read = 1'b1; id_reg1_addr = 5'd5;
    step();
    idle();
    step();
    // same with x0 destination
    ex_is_load = 1'b1; ex_waddr = 5'd0; id_reg1_read = 1'b1; id_reg1_addr = 5'd0;
    step();
    // two back-to-back load-use pairs via rs2
    idle();
    ex_is_load = 1'b1; ex_waddr = 5'd9; id_reg2_read = 1'b1; id_reg2_addr = 5'd9;
    step();
    step();
    idle();
    step();

    // memory wait for 3 cycles then ready
    mem_req = 1'b1;
    repeat (3) step();
    mem_ready = 1'b1;
    step();
    idle();
    step();

    // same-cycle req+ready
    mem_req = 1'b1; mem_ready = 1'b1;
    step();
    idle();

    // branch with no hazard
    id_branch_flag = 1'b1;
    step();
    idle();

    // priority: all hazards plus branch, then ready with branch held
    ex_is_load = 1'b1; ex_waddr = 5'd3; id_reg1_read = 1'b1; id_reg1_addr = 5'd3;
    id_branch_flag = 1'b1; mem_req = 1'b1;
    step();
    step();
    ex_is_load = 1'b0; mem_ready = 1'b1;
    step();
    idle();

    // watchdog: 6 wait cycles, then ready, flag stays
    mem_req = 1'b1;
    repeat (6) step();
    mem_ready = 1'b1;
    step();
    idle();
    step();
    step();

    // reset mid-wait
    mem_req = 1'b1;
    repeat (2) step();
    rst = 1'b1;
    repeat (2) step();
    idle();
    step();
    mem_req = 1'b1;
    step();
    idle();
    step();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(0, 59) == 0);
      id_reg1_read   = $urandom_range(0, 1);
      id_reg1_addr   = 5'($urandom_range(0, 3));
      id_reg2_read   = $urandom_range(0, 1);
      id_reg2_addr   = 5'($urandom_range(0, 3));
      id_branch_flag = ($urandom_range(0, 3) == 0);
      ex_is_load     = $urandom_range(0, 1);
      ex_waddr       = 5'($urandom_range(0, 3));
      mem_req        = ($urandom_range(0, 2) == 0);
      mem_ready      = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 99) < 3) mem_ready = 1'b0;
      step();
      // occasionally hold a long wait to exercise the watchdog
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b0; mem_req = 1'b1; mem_ready = 1'b0;
        repeat (WT + 2) step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
